// File: rtl/serial_shift_transmitter_pkg.sv
// Shared definitions for the framed serial transmitter: FSM encoding, line levels, width helper.
package serial_shift_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic LINE_IDLE  = 1'b1;
  localparam logic LINE_START = 1'b0;

  // Counter width for a 0..n-1 range, never narrower than one bit.
  function automatic int unsigned min1_clog2(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_bit_timer.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 while enabled, pulses bitDone on the wrap cycle.
module serial_bit_timer
  import serial_shift_transmitter_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  output logic bitDone
);

  localparam int unsigned TW = min1_clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] LAST = TW'(CLKS_PER_BIT - 1);

  logic [TW-1:0] bitTimer;

  // Asserted during the last clock of a bit so the FSM moves on at the following edge.
  assign bitDone = enable && (bitTimer == LAST);

  always_ff @(posedge clock) begin
    if (reset || !enable || bitDone) begin
      bitTimer <= '0;
    end else begin
      bitTimer <= bitTimer + 1'b1;
    end
  end

endmodule

// File: rtl/serial_shift_transmitter.sv
// Parallel-in serial-out framed transmitter: start bit, DATA_WIDTH bits LSB first, stop bit.
module serial_shift_transmitter
  import serial_shift_transmitter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] txData,
  input  logic                  txValid,
  output logic                  txReady,
  output logic                  serialOut,
  output logic                  busy
);

  localparam int unsigned BW = min1_clog2(DATA_WIDTH);
  localparam logic [BW-1:0] LAST_IDX = BW'(DATA_WIDTH - 1);

  tx_state_t             state;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] shiftNext;
  logic [BW-1:0]         bitIndex;
  logic                  bitDone;

  assign shiftNext = shift >> 1;

  // The timer runs for the whole frame; busy is exactly "not IDLE".
  serial_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clock  (clock),
    .reset  (reset),
    .enable (busy),
    .bitDone(bitDone)
  );

  // Outputs are loaded with the value belonging to the state being entered.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      shift     <= '0;
      bitIndex  <= '0;
      serialOut <= LINE_IDLE;
      txReady   <= 1'b1;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (txValid && txReady) begin
            state     <= START;
            shift     <= txData;
            serialOut <= LINE_START;
            txReady   <= 1'b0;
            busy      <= 1'b1;
          end
        end
        START: begin
          if (bitDone) begin
            state     <= DATA;
            bitIndex  <= '0;
            serialOut <= shift[0];
          end
        end
        DATA: begin
          if (bitDone) begin
            shift <= shiftNext;
            if (bitIndex == LAST_IDX) begin
              state     <= STOP;
              bitIndex  <= '0;
              serialOut <= LINE_IDLE;
            end else begin
              bitIndex  <= bitIndex + 1'b1;
              serialOut <= shiftNext[0];
            end
          end
        end
        STOP: begin
          if (bitDone) begin
            state   <= IDLE;
            txReady <= 1'b1;
            busy    <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_shift_transmitter.sv
// Randomised self-checking bench: frame-level reference model plus a DATA_WIDTH=1, CLKS_PER_BIT=1 build.
module tb_serial_shift_transmitter;

  localparam int W     = 8;
  localparam int CPB   = 4;
  localparam int FRAME = (W + 2) * CPB;

  logic       clock   = 1'b0;
  logic       reset   = 1'b1;
  logic [7:0] txData  = 8'h00;
  logic       txValid = 1'b0;
  logic       txReady, serialOut, busy;

  logic [0:0] txData1  = 1'b0;
  logic       txValid1 = 1'b0;
  logic       txReady1, serialOut1, busy1;

  always #5 clock = ~clock;

  serial_shift_transmitter #(.DATA_WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .txData(txData), .txValid(txValid),
    .txReady(txReady), .serialOut(serialOut), .busy(busy)
  );

  serial_shift_transmitter #(.DATA_WIDTH(1), .CLKS_PER_BIT(1)) dut1 (
    .clock(clock), .reset(reset), .txData(txData1), .txValid(txValid1),
    .txReady(txReady1), .serialOut(serialOut1), .busy(busy1)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Reference model: a frame is just the accept edge and the captured word.
  bit         m_busy  = 1'b0;
  int         m_start = 0;
  int         cyc     = 0;
  int         accepts = 0;
  logic [7:0] m_word  = 8'h00;

  function automatic logic exp_line();
    int k, b;
    if (!m_busy) return 1'b1;
    k = cyc - m_start;
    b = k / CPB;
    if (b == 0) return 1'b0;
    if (b <= W) return m_word[b-1];
    return 1'b1;
  endfunction

  task automatic tick();
    @(posedge clock);
    cyc++;
    if (reset) begin
      m_busy = 1'b0;
    end else if (m_busy) begin
      if (cyc - m_start == FRAME) m_busy = 1'b0;
    end else if (txValid) begin
      m_busy  = 1'b1;
      m_start = cyc;
      m_word  = txData;
      accepts++;
    end
    #1;
    check("serialOut", 32'(serialOut), 32'(exp_line()));
    check("txReady", 32'(txReady), 32'(!m_busy));
    check("busy", 32'(busy), 32'(m_busy));
  endtask

  initial begin
    int lowcnt, gap, a0, guard, acc_before;
    logic [3:0] exp1_line, exp1_ready;

    // Reset, then a quiet line.
    repeat (2) tick();
    reset = 1'b0;
    repeat (20) tick();

    // Single 0xA5 frame; txReady must be low for exactly one frame length.
    txData = 8'hA5; txValid = 1'b1;
    tick();
    txValid = 1'b0;
    lowcnt = (txReady == 1'b0) ? 1 : 0;
    repeat (44) begin
      tick();
      if (txReady == 1'b0) lowcnt++;
    end
    check("a5_ready_low_cycles", 32'(lowcnt), 32'(FRAME));

    // Back-to-back with txValid held: 0x00 then 0xFF, one idle cycle between frames.
    a0 = accepts;
    txData = 8'h00; txValid = 1'b1;
    tick();
    txData = 8'hFF;
    gap = 0; guard = 0;
    while (accepts < a0 + 2 && guard < 100) begin
      tick();
      if (busy == 1'b0) gap++;
      guard++;
    end
    check("b2b_timeout", 32'(guard < 100), 32'd1);
    check("b2b_idle_gap", 32'(gap), 32'd1);
    txValid = 1'b0;
    repeat (10) tick();
    txData = 8'h00;
    repeat (35) tick();

    // Reset during data bit 3 of 0x3C, then a clean 0x81.
    txData = 8'h3C; txValid = 1'b1;
    tick();
    txValid = 1'b0;
    repeat (17) tick();
    reset = 1'b1;
    tick();
    check("midframe_reset_line", 32'(serialOut), 32'd1);
    reset = 1'b0;
    tick();
    txData = 8'h81; txValid = 1'b1;
    tick();
    txValid = 1'b0;
    repeat (44) tick();

    // Reset together with txValid: nothing is accepted.
    acc_before = accepts;
    reset = 1'b1; txValid = 1'b1; txData = 8'h55;
    tick();
    reset = 1'b0; txValid = 1'b0;
    repeat (10) tick();
    check("reset_beats_valid_no_frame", 32'(busy), 32'd0);
    check("reset_beats_valid_accepts", 32'(accepts), 32'(acc_before));

    // Random traffic with ever-changing txData and occasional resets.
    repeat (1500) begin
      txData  = 8'($urandom);
      txValid = ($urandom_range(0, 3) == 0);
      reset   = ($urandom_range(0, 299) == 0);
      tick();
    end
    reset = 1'b0; txValid = 1'b0;
    repeat (FRAME + 2) tick();

    // One-bit word, one clock per bit: start, data, stop, then ready on the 4th cycle.
    for (int w = 0; w < 2; w++) begin
      exp1_line  = {1'b1, 1'b1, 1'(w), 1'b0};
      exp1_ready = 4'b1000;
      txData1 = 1'(w); txValid1 = 1'b1;
      tick();
      txValid1 = 1'b0;
      for (int i = 0; i < 4; i++) begin
        if (i > 0) tick();
        check($sformatf("w1c1_line_w%0d_c%0d", w, i), 32'(serialOut1), 32'(exp1_line[i]));
        check($sformatf("w1c1_ready_w%0d_c%0d", w, i), 32'(txReady1), 32'(exp1_ready[i]));
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
